mul_unit: RTL and testbench

Iterative 32×32 shift-add multiplier in the execute path, beside the ALU. The controller raises `start` when it decodes a multiply instruction whose condition passes. The unit stalls fetch and writeback through `stall` for the whole operation. It returns the product and its N/Z flags with a one-cycle `done` pulse, in the cycle the destination register is written.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_unit.sv | 126 ++++++++++++
 tb/tb_mul_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, FSM state type and flag helper for mul_unit.
// Build option: define MUL_LONG_EN for a 64-bit product (result_hi port, N from bit 63).
package mul_pkg;

    localparam int MUL_XLEN = 32;
    localparam int MUL_ITER = 32;
    localparam int MUL_CNTW = 5;

`ifdef MUL_LONG_EN
    localparam int MUL_ACCW = 64;
`else
    localparam int MUL_ACCW = 32;
`endif

    // Counter value seen during the final shift-add iteration.
    localparam logic [MUL_CNTW-1:0] MUL_CNT_LAST = MUL_CNTW'(MUL_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // {N, Z} of a product: N is the top bit, Z covers every bit held.
    function automatic logic [1:0] mul_flags(input logic [MUL_ACCW-1:0] prod);
        return {prod[MUL_ACCW-1], (prod == {MUL_ACCW{1'b0}})};
    endfunction

endpackage

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier, one multiplier bit per cycle.
// 32 RUN cycles, then a one-cycle DONE that carries the product and flags.
// Build option: MUL_LONG_EN widens the accumulator to 64 bits and adds result_hi.
module mul_unit
    import mul_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MUL_XLEN-1:0] srca,
    input  logic [MUL_XLEN-1:0] srcb,
    output logic                stall,
    output logic                done,
    output logic [MUL_XLEN-1:0] result,
`ifdef MUL_LONG_EN
    output logic [MUL_XLEN-1:0] result_hi,
`endif
    output logic [1:0]          mulflags
);

    mul_state_e          state_r;
    mul_state_e          state_nxt_s;
    logic [MUL_ACCW-1:0] a_r;
    logic [MUL_ACCW-1:0] acc_r;
    logic [MUL_ACCW-1:0] sum_s;
    logic [MUL_ACCW-1:0] prod_r;
    logic [MUL_XLEN-1:0] b_r;
    logic [MUL_CNTW-1:0] cnt_r;
    logic [1:0]          flags_r;
    logic                done_r;
    logic                last_s;

    // Partial-sum adder (carry out dropped) and final-iteration detect.
    always_comb begin
        sum_s  = acc_r + (b_r[0] ? a_r : {MUL_ACCW{1'b0}});
        last_s = (state_r == RUN) && (cnt_r == MUL_CNT_LAST);
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shift-add datapath: load operands on accept, then one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_r   <= {MUL_ACCW{1'b0}};
            b_r   <= {MUL_XLEN{1'b0}};
            acc_r <= {MUL_ACCW{1'b0}};
            cnt_r <= {MUL_CNTW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r   <= MUL_ACCW'(srca);
                        b_r   <= srcb;
                        acc_r <= {MUL_ACCW{1'b0}};
                        cnt_r <= {MUL_CNTW{1'b0}};
                    end
                end
                RUN: begin
                    acc_r <= sum_s;
                    a_r   <= {a_r[MUL_ACCW-2:0], 1'b0};
                    b_r   <= {1'b0, b_r[MUL_XLEN-1:1]};
                    cnt_r <= cnt_r + 5'd1;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Result/flag capture on the final iteration; held until the next one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_r  <= {MUL_ACCW{1'b0}};
            flags_r <= 2'b01;
            done_r  <= 1'b0;
        end else begin
            done_r <= last_s;
            if (last_s) begin
                prod_r  <= sum_s;
                flags_r <= mul_flags(sum_s);
            end
        end
    end

    // stall must follow start combinationally in IDLE so the fetch stage
    // freezes in the same cycle the multiply is decoded.
    assign stall    = ((state_r == IDLE) && start) || (state_r == RUN);
    assign done     = done_r;
    assign result   = prod_r[MUL_XLEN-1:0];
`ifdef MUL_LONG_EN
    assign result_hi = prod_r[MUL_ACCW-1:MUL_XLEN];
`endif
    assign mulflags = flags_r;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed bench for mul_unit with a scoreboard of expected products.
// Honours MUL_LONG_EN when the design is built with it.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        stall;
    logic        done;
    logic [31:0] result;
`ifdef MUL_LONG_EN
    logic [31:0] result_hi;
`endif
    logic [1:0]  mulflags;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  fl;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   passed = 0;
    int   total  = 0;
    logic done_seen;

    always #5 clk = ~clk;

    mul_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .srca     (srca),
        .srcb     (srcb),
        .stall    (stall),
        .done     (done),
        .result   (result),
`ifdef MUL_LONG_EN
        .result_hi(result_hi),
`endif
        .mulflags (mulflags)
    );

    // Reference product computed with a plain 64-bit multiply.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        exp_t        e;
        p    = {32'd0, a} * {32'd0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
`ifdef MUL_LONG_EN
        e.fl = {p[63], (p == 64'd0)};
`else
        e.fl = {p[31], (p[31:0] == 32'd0)};
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, ".result"}, 64'(result), 64'(e.lo));
        chk({tag, ".flags"}, 64'(mulflags), 64'(e.fl));
`ifdef MUL_LONG_EN
        chk({tag, ".result_hi"}, 64'(result_hi), 64'(e.hi));
`endif
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Check stall/done in the current cycle; on done, pop and compare the scoreboard.
    task automatic chk_cycle(input string tag, input logic exp_stall, input logic exp_done);
        #1;
        chk({tag, ".stall"}, 64'(stall), 64'(exp_stall));
        chk({tag, ".done"}, 64'(done), 64'(exp_done));
        if (exp_done && done === 1'b1) begin
            total++;
            assert (sb_q.size() > 0) passed++;
            else $error("FAIL %s.sb: got empty scoreboard, want one entry", tag);
            if (sb_q.size() > 0) begin
                last_exp = sb_q.pop_front();
                check_result(tag, last_exp);
            end
        end
    endtask

    // One multiply from an IDLE cycle; leaves the bench in the cycle after DONE.
    // hold keeps start high throughout and scrambles operands mid-RUN.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
        srca  = a;
        srcb  = b;
        start = 1'b1;
        sb_q.push_back(model(a, b));
        chk_cycle("accept", 1'b1, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            next_cycle();
            start = hold;
            if (hold && k == 5) begin
                srca = $urandom;
                srcb = $urandom;
            end
            chk_cycle("run", 1'b1, 1'b0);
        end
        next_cycle();
        chk_cycle("done", 1'b0, 1'b1);
        next_cycle();
    endtask

    task automatic idle_check();
        start = 1'b0;
        chk_cycle("idle", 1'b0, 1'b0);
        check_result("hold", last_exp);
        next_cycle();
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        srca  = 32'd0;
        srcb  = 32'd0;
        last_exp = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_cycle("rst", 1'b0, 1'b0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.flags", 64'(mulflags), 64'd1);
`ifdef MUL_LONG_EN
        chk("rst.result_hi", 64'(result_hi), 64'd0);
`endif
        start = 1'b1;
        #1;
        chk("rst.stall_start", 64'(stall), 64'd1);
        start = 1'b0;
        next_cycle();
        reset = 1'b1;

        do_op(32'd3, 32'd5, 1'b0);
        idle_check();
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle_check();
        do_op(32'h1234_5678, 32'd0, 1'b0);
        idle_check();
        do_op(32'd1, 32'd1, 1'b0);
        idle_check();

        // Busy-start and back-to-back: start stays high across consecutive ops.
        do_op($urandom, $urandom, 1'b1);
        do_op($urandom, $urandom, 1'b1);
        do_op(32'h8000_0001, 32'h0000_0003, 1'b0);
        idle_check();

        // Reset during RUN discards the operation.
        srca  = 32'hDEAD_BEEF;
        srcb  = 32'h0000_1234;
        start = 1'b1;
        chk_cycle("racc", 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            start = 1'b0;
            chk_cycle("rrun", 1'b1, 1'b0);
        end
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        chk_cycle("rmid", 1'b0, 1'b0);
        chk("rmid.result", 64'(result), 64'd0);
        chk("rmid.flags", 64'(mulflags), 64'd1);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            #1;
            if (done !== 1'b0 || stall !== 1'b0) done_seen = 1'b1;
        end
        chk("rmid.quiet", 64'(done_seen), 64'd0);
        next_cycle();
        do_op(32'd7, 32'd6, 1'b0);
        idle_check();

        total++;
        assert (sb_q.size() == 0) passed++;
        else $error("FAIL sb.drain: got %0d entries left, want 0", sb_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
